// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM state
// encodings, the full-word byte-enable pattern and default geometry/latency.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_WAIT = 2'd1,
    MEM_ST_RESP = 2'd2
  } mem_state_e;

  localparam logic [3:0] MEM_BE_WORD             = 4'b1111;
  localparam int         MEM_DEF_ADDR_WORDS_LOG2 = 10;
  localparam int         MEM_DEF_WAIT_CYCLES     = 2;

endpackage

// File: rtl/data_mem_responder_array.sv
// Word-organised storage: synchronous write with four byte lanes,
// combinational read. Contents are deliberately not reset.
module data_mem_responder_array
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WORDS_LOG2 = MEM_DEF_ADDR_WORDS_LOG2
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [ADDR_WORDS_LOG2-1:0] i_word_addr,
  input  logic [31:0]                i_write_data,
  input  logic [3:0]                 i_byte_en,
  output logic [31:0]                o_read_data
);

  logic [31:0] r_mem [2**ADDR_WORDS_LOG2];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_we && i_byte_en[i]) begin
        r_mem[i_word_addr][8*i +: 8] <= i_write_data[8*i +: 8];
      end
    end
  end

  assign o_read_data = r_mem[i_word_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: accepts a read or write request, waits a fixed number
// of cycles, then performs the access and pulses o_ready for one cycle.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WORDS_LOG2 = MEM_DEF_ADDR_WORDS_LOG2,
  parameter int WAIT_CYCLES     = MEM_DEF_WAIT_CYCLES,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_ctrl_mem_read,
  input  logic                  i_ctrl_mem_write,
  input  logic [31:0]           i_addr,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic [3:0]            i_byte_en,
  output logic [DATA_WIDTH-1:0] o_read_data,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_addr_error
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

  mem_state_e                 r_state, w_next_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [ADDR_WORDS_LOG2-1:0] r_word_addr;
  logic [DATA_WIDTH-1:0]      r_write_data;
  logic [3:0]                 r_byte_en;
  logic                       r_is_write;
  logic                       r_err;

  logic        w_req, w_accept, w_misaligned, w_out_of_range, w_err, w_mem_we;
  logic [31:0] w_mem_rdata;

  assign w_req          = i_ctrl_mem_read | i_ctrl_mem_write;
  assign w_accept       = (r_state == MEM_ST_IDLE) && w_req;
  assign w_out_of_range = |i_addr[31:ADDR_WORDS_LOG2+2];
  // A misaligned partial-lane store is allowed; only full-word stores must be aligned.
  assign w_misaligned   = (i_addr[1:0] != 2'b00) &&
                          (i_ctrl_mem_read || (i_ctrl_mem_write && i_byte_en == MEM_BE_WORD));
  assign w_err          = (i_ctrl_mem_read & i_ctrl_mem_write) | w_out_of_range | w_misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MEM_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_word_addr  <= '0;
      r_write_data <= '0;
      r_byte_en    <= '0;
      r_is_write   <= 1'b0;
      r_err        <= 1'b0;
    end else if (w_accept) begin
      r_cnt        <= CNT_W'(WAIT_CYCLES);
      r_word_addr  <= i_addr[ADDR_WORDS_LOG2+1:2];
      r_write_data <= i_write_data;
      r_byte_en    <= i_byte_en;
      r_is_write   <= i_ctrl_mem_write;
      r_err        <= w_err;
    end else if (r_state == MEM_ST_WAIT) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_ready      = 1'b0;
    o_busy       = 1'b0;
    case (r_state)
      MEM_ST_IDLE: begin
        if (w_req) w_next_state = (WAIT_CYCLES == 0) ? MEM_ST_RESP : MEM_ST_WAIT;
      end
      MEM_ST_WAIT: begin
        o_busy = 1'b1;
        if (r_cnt == CNT_W'(1)) w_next_state = MEM_ST_RESP;
      end
      MEM_ST_RESP: begin
        o_busy       = 1'b1;
        o_ready      = 1'b1;
        w_next_state = MEM_ST_IDLE;
      end
      default: w_next_state = MEM_ST_IDLE;
    endcase
  end

  assign w_mem_we     = o_ready & r_is_write & ~r_err;
  assign o_addr_error = o_ready & r_err;
  assign o_read_data  = (o_ready && !r_is_write && !r_err) ? w_mem_rdata : '0;

  data_mem_responder_array #(
    .ADDR_WORDS_LOG2(ADDR_WORDS_LOG2)
  ) u_array (
    .clk          (clk),
    .i_we         (w_mem_we),
    .i_word_addr  (r_word_addr),
    .i_write_data (r_write_data),
    .i_byte_en    (r_byte_en),
    .o_read_data  (w_mem_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with two wait states, one with none.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_rd = 0, a_wr = 0, b_rd = 0, b_wr = 0;
  logic [31:0] a_addr = 0, a_wd = 0, b_addr = 0, b_wd = 0;
  logic [3:0]  a_be = 0, b_be = 0;
  logic [31:0] a_rdata, b_rdata;
  logic        a_ready, a_busy, a_err, b_ready, b_busy, b_err;

  int total = 0;
  int bad   = 0;

  data_mem_responder #(.ADDR_WORDS_LOG2(10), .WAIT_CYCLES(2), .DATA_WIDTH(32)) u_w2 (
    .clk(clk), .rst_n(rst_n),
    .i_ctrl_mem_read(a_rd), .i_ctrl_mem_write(a_wr), .i_addr(a_addr),
    .i_write_data(a_wd), .i_byte_en(a_be),
    .o_read_data(a_rdata), .o_ready(a_ready), .o_busy(a_busy), .o_addr_error(a_err)
  );

  data_mem_responder #(.ADDR_WORDS_LOG2(10), .WAIT_CYCLES(0), .DATA_WIDTH(32)) u_w0 (
    .clk(clk), .rst_n(rst_n),
    .i_ctrl_mem_read(b_rd), .i_ctrl_mem_write(b_wr), .i_addr(b_addr),
    .i_write_data(b_wd), .i_byte_en(b_be),
    .o_read_data(b_rdata), .o_ready(b_ready), .o_busy(b_busy), .o_addr_error(b_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    if (sel == 0) begin
      a_rd = rd; a_wr = wr; a_addr = addr; a_wd = wd; a_be = be;
    end else begin
      b_rd = rd; b_wr = wr; b_addr = addr; b_wd = wd; b_be = be;
    end
  endtask

  // Presents a request at a negedge, waits (bounded) for o_ready, drops the request.
  task automatic txn(input int sel, input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be, input bit glitch,
                     output logic [31:0] rdata, output logic err, output int lat);
    logic rdy;
    @(negedge clk);
    drive(sel, rd, wr, addr, wd, be);
    lat = 0;
    rdy = 1'b0;
    rdata = '0;
    err = 1'b0;
    while (!rdy && lat < 20) begin
      @(negedge clk);
      lat++;
      rdy   = (sel == 0) ? a_ready : b_ready;
      rdata = (sel == 0) ? a_rdata : b_rdata;
      err   = (sel == 0) ? a_err   : b_err;
      if (lat == 1) check("busy_in_flight", (sel == 0) ? a_busy : b_busy, 1'b1);
      if (glitch && lat == 1) drive(sel, rd, wr, addr ^ 32'h30, ~wd, ~be);
    end
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  logic [31:0] rdata;
  logic        err;
  int          lat;

  initial begin
    // 1: reset held with requests asserted
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b1, 32'h10, 32'h1, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", a_ready, 1'b0);
      check("rst_busy", a_busy, 1'b0);
      check("rst_rdata", a_rdata, 32'h0);
      check("rst_err", a_err, 1'b0);
      check("rst_ready_w0", b_ready, 1'b0);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2: full-word write then read, two wait states
    txn(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rdata, err, lat);
    check("wr10_lat", lat, 3);
    check("wr10_err", err, 1'b0);
    check("wr10_rdata", rdata, 32'h0);
    txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rdata, err, lat);
    check("rd10_lat", lat, 3);
    check("rd10_err", err, 1'b0);
    check("rd10_data", rdata, 32'hDEADBEEF);

    // 3: byte enables, zero enables, misaligned partial store
    txn(0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, rdata, err, lat);
    txn(0, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, rdata, err, lat);
    txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rdata, err, lat);
    check("be0101_data", rdata, 32'h11BB33DD);
    txn(0, 1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b0, rdata, err, lat);
    check("be0000_err", err, 1'b0);
    check("be0000_lat", lat, 3);
    txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rdata, err, lat);
    check("be0000_data", rdata, 32'h11BB33DD);
    txn(0, 1'b0, 1'b1, 32'h21, 32'h000000EE, 4'b0001, 1'b0, rdata, err, lat);
    check("misal_part_err", err, 1'b0);
    txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rdata, err, lat);
    check("misal_part_data", rdata, 32'h11BB33EE);

    // 4: error cases
    txn(0, 1'b1, 1'b0, 32'h13, 32'h0, 4'h0, 1'b0, rdata, err, lat);
    check("rd13_err", err, 1'b1);
    check("rd13_lat", lat, 3);
    check("rd13_rdata", rdata, 32'h0);
    txn(0, 1'b0, 1'b1, 32'h12, 32'h0, 4'hF, 1'b0, rdata, err, lat);
    check("wr12_err", err, 1'b1);
    txn(0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b0, rdata, err, lat);
    check("rd1000_err", err, 1'b1);
    check("rd1000_rdata", rdata, 32'h0);
    txn(0, 1'b0, 1'b1, 32'h1010, 32'h0, 4'hF, 1'b0, rdata, err, lat);
    check("wr1010_err", err, 1'b1);
    txn(0, 1'b1, 1'b0, 32'hFFC, 32'h0, 4'h0, 1'b0, rdata, err, lat);
    check("rdFFC_err", err, 1'b0);
    txn(0, 1'b1, 1'b1, 32'h10, 32'h0, 4'hF, 1'b0, rdata, err, lat);
    check("rdwr_err", err, 1'b1);
    check("rdwr_rdata", rdata, 32'h0);
    check("rdwr_lat", lat, 3);
    txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rdata, err, lat);
    check("after_err_data", rdata, 32'hDEADBEEF);
    txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rdata, err, lat);
    check("after_err_data20", rdata, 32'h11BB33EE);

    // inputs changed while in flight are ignored
    txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, rdata, err, lat);
    check("glitch_rd_data", rdata, 32'hDEADBEEF);
    txn(0, 1'b0, 1'b1, 32'h10, 32'h01020304, 4'hF, 1'b1, rdata, err, lat);
    txn(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rdata, err, lat);
    check("glitch_wr_data", rdata, 32'h01020304);
    txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rdata, err, lat);
    check("glitch_wr_other", rdata, 32'h11BB33EE);

    // 5: zero wait states, back-to-back write then read of the same word
    txn(1, 1'b0, 1'b1, 32'h30, 32'h12345678, 4'hF, 1'b0, rdata, err, lat);
    check("w0_wr_lat", lat, 1);
    check("w0_wr_err", err, 1'b0);
    txn(1, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, rdata, err, lat);
    check("w0_rd_lat", lat, 1);
    check("w0_rd_data", rdata, 32'h12345678);
    txn(1, 1'b0, 1'b1, 32'h30, 32'h9ABC0000, 4'b1100, 1'b0, rdata, err, lat);
    txn(1, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, rdata, err, lat);
    check("w0_raw_data", rdata, 32'h9ABC5678);
    txn(1, 1'b1, 1'b0, 32'h31, 32'h0, 4'h0, 1'b0, rdata, err, lat);
    check("w0_misal_err", err, 1'b1);
    check("w0_misal_lat", lat, 1);

    // 6: reset during the wait of a write leaves memory untouched
    txn(0, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 1'b0, rdata, err, lat);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h40, 32'h0BADBEEF, 4'hF);
    @(negedge clk);
    check("midwait_busy", a_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", a_busy, 1'b0);
    check("midrst_ready", a_ready, 1'b0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_noready", a_ready, 1'b0);
    end
    rst_n = 1'b1;
    txn(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, rdata, err, lat);
    check("post_rst_data", rdata, 32'hCAFEF00D);
    check("post_rst_lat", lat, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
